// File: rtl/status_pack_if.sv
// status_pack_if: upstream byte and downstream word handshakes of status_pack
interface status_pack_if;
  logic [7:0]  in_code;
  logic        in_vld;
  logic        in_rdy;
  logic        flush;
  logic [15:0] out_pl;
  logic        out_half;
  logic        out_vld;
  logic        out_rdy;
  modport master (
    output in_code, in_vld, flush, out_rdy,
    input  in_rdy, out_pl, out_half, out_vld
  );
  modport slave (
    input  in_code, in_vld, flush, out_rdy,
    output in_rdy, out_pl, out_half, out_vld
  );
endinterface

// File: rtl/status_pack.sv
// status_pack: packs status byte pairs into 16-bit words, padding a lone byte on flush or idle timeout
module status_pack #(
  parameter int         TIMEOUT = 16,
  parameter logic [7:0] PAD     = 8'h00
) (
  input  logic         clock,
  input  logic         rst_n,
  status_pack_if.slave bus,
  output logic [15:0]  word_cnt
);
  typedef enum logic [1:0] {IDLE, HOLD, SEND} state_t;
  state_t      r_state, w_next;
  logic [15:0] r_pl, r_idle, r_word_cnt;
  logic        r_half, w_in_xfer, w_out_xfer, w_tmo, w_close;
  assign w_in_xfer  = bus.in_vld && bus.in_rdy;
  assign w_out_xfer = bus.out_vld && bus.out_rdy;
  assign w_tmo      = r_idle == 16'(TIMEOUT - 1);
  assign w_close    = w_in_xfer || bus.flush || w_tmo;
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb
    w_next = (r_state == IDLE) ? (w_in_xfer ? HOLD : IDLE) :
             (r_state == HOLD) ? (w_close ? SEND : HOLD) :
             (r_state == SEND) ? (w_out_xfer ? IDLE : SEND) : IDLE;
  always_comb begin
    bus.in_rdy  = r_state != SEND;
    bus.out_vld = r_state == SEND;
  end
  assign bus.out_pl   = r_pl;
  assign bus.out_half = r_half;
  assign word_cnt     = r_word_cnt;
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      r_pl       <= '0;
      r_half     <= 1'b0;
      r_idle     <= '0;
      r_word_cnt <= '0;
    end else begin
      if (r_state == IDLE && w_in_xfer) r_pl[15:8] <= bus.in_code;
      if (r_state == HOLD && w_close) begin
        r_pl[7:0] <= w_in_xfer ? bus.in_code : PAD;
        r_half    <= !w_in_xfer;
      end
      r_idle <= (r_state == HOLD && !w_in_xfer) ? r_idle + 16'd1 : 16'd0;
      if (w_out_xfer && r_word_cnt != 16'hFFFF) r_word_cnt <= r_word_cnt + 16'd1;
    end
endmodule

// File: tb/tb_status_pack.sv
// tb_status_pack: table-driven and directed checks of status_pack
module tb_status_pack;
  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] word_cnt;
  int          errors = 0;
  int          checks = 0;
  status_pack_if bus ();
  status_pack #(.TIMEOUT(16), .PAD(8'h00)) dut (
    .clock(clock),
    .rst_n(rst_n),
    .bus(bus),
    .word_cnt(word_cnt)
  );
  always #5 clock = ~clock;
  typedef struct {
    logic        vld;
    logic [7:0]  code;
    logic        flush;
    logic        ordy;
    logic [34:0] exp;
  } vec_t;
  vec_t tv[14];
  function automatic logic [34:0] e(input logic rdy, input logic ovld, input logic half,
                                    input logic [15:0] pl, input logic [15:0] cnt);
    return {rdy, ovld, half, pl, cnt};
  endfunction
  function automatic logic [34:0] cur();
    return {bus.in_rdy, bus.out_vld, bus.out_half, bus.out_pl, word_cnt};
  endfunction
  task automatic chk(input string name, input logic [34:0] act, input logic [34:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h ({in_rdy,out_vld,out_half,out_pl,word_cnt})", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    logic [7:0] c1, c2;
    tv[0]  = '{1'b1, 8'h12, 1'b0, 1'b1, e(1, 0, 0, 16'h0000, 16'd0)};
    tv[1]  = '{1'b1, 8'h34, 1'b0, 1'b1, e(1, 0, 0, 16'h1200, 16'd0)};
    tv[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, e(0, 1, 0, 16'h1234, 16'd0)};
    tv[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, e(1, 0, 0, 16'h1234, 16'd1)};
    tv[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, e(1, 0, 0, 16'h1234, 16'd1)};
    tv[5]  = '{1'b1, 8'h01, 1'b0, 1'b1, e(1, 0, 0, 16'h1234, 16'd1)};
    tv[6]  = '{1'b1, 8'h02, 1'b1, 1'b1, e(1, 0, 0, 16'h0134, 16'd1)};
    tv[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, e(0, 1, 0, 16'h0102, 16'd1)};
    tv[8]  = '{1'b1, 8'h01, 1'b0, 1'b1, e(1, 0, 0, 16'h0102, 16'd2)};
    tv[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, e(1, 0, 0, 16'h0102, 16'd2)};
    tv[10] = '{1'b1, 8'h55, 1'b0, 1'b0, e(0, 1, 1, 16'h0100, 16'd2)};
    tv[11] = '{1'b1, 8'h55, 1'b0, 1'b1, e(0, 1, 1, 16'h0100, 16'd2)};
    tv[12] = '{1'b1, 8'h55, 1'b0, 1'b1, e(1, 0, 1, 16'h0100, 16'd3)};
    tv[13] = '{1'b0, 8'h00, 1'b0, 1'b1, e(1, 0, 1, 16'h5500, 16'd3)};
    bus.in_vld  = 1'b0;
    bus.in_code = 8'h00;
    bus.flush   = 1'b0;
    bus.out_rdy = 1'b1;
    repeat (2) @(negedge clock);
    chk("reset_state", cur(), e(1, 0, 0, 16'h0000, 16'd0));
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clock);
      bus.in_vld  = tv[i].vld;
      bus.in_code = tv[i].code;
      bus.flush   = tv[i].flush;
      bus.out_rdy = tv[i].ordy;
      #1 chk($sformatf("vec%0d", i), cur(), tv[i].exp);
    end
    rst_n = 1'b0;
    #1 chk("rst_in_hold", cur(), e(1, 0, 0, 16'h0000, 16'd0));
    @(negedge clock);
    rst_n       = 1'b1;
    bus.in_vld  = 1'b1;
    bus.in_code = 8'hA5;
    bus.flush   = 1'b0;
    bus.out_rdy = 1'b1;
    step();
    bus.in_vld = 1'b0;
    n = 0;
    while (!bus.out_vld && n < 40) begin
      step();
      n++;
    end
    chk("tmo_cycles", 35'(n), 35'd16);
    chk("tmo_word", cur(), e(0, 1, 1, 16'hA500, 16'd0));
    step();
    chk("tmo_cnt", cur(), e(1, 0, 1, 16'hA500, 16'd1));
    bus.out_rdy = 1'b0;
    bus.in_vld  = 1'b1;
    bus.in_code = 8'h11;
    step();
    bus.in_code = 8'h22;
    step();
    bus.in_code = 8'h33;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("bp_hold%0d", k), cur(), e(0, 1, 0, 16'h1122, 16'd1));
      step();
    end
    bus.out_rdy = 1'b1;
    step();
    chk("bp_release", cur(), e(1, 0, 0, 16'h1122, 16'd2));
    step();
    chk("bp_next_byte", cur(), e(1, 0, 0, 16'h3322, 16'd2));
    bus.in_code = 8'h44;
    bus.out_rdy = 1'b0;
    step();
    chk("send_before_rst", cur(), e(0, 1, 0, 16'h3344, 16'd2));
    rst_n = 1'b0;
    #1 chk("rst_in_send", cur(), e(1, 0, 0, 16'h0000, 16'd0));
    @(negedge clock);
    rst_n       = 1'b1;
    bus.in_vld  = 1'b0;
    bus.out_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("no_stale%0d", k), cur(), e(1, 0, 0, 16'h0000, 16'd0));
    end
    bus.in_vld  = 1'b1;
    bus.in_code = 8'h77;
    step();
    chk("first_accept", cur(), e(1, 0, 0, 16'h7700, 16'd0));
    bus.in_vld = 1'b0;
    bus.flush  = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("flush_alone", cur(), e(0, 1, 1, 16'h7700, 16'd0));
    step();
    chk("flush_done", cur(), e(1, 0, 1, 16'h7700, 16'd1));
    force dut.r_word_cnt = 16'hFFFE;
    step();
    release dut.r_word_cnt;
    step();
    chk("sat_preload", cur(), e(1, 0, 1, 16'h7700, 16'hFFFE));
    for (int w = 0; w < 3; w++) begin
      c1 = 8'hC0 + 8'(w);
      c2 = 8'hD0 + 8'(w);
      bus.in_vld  = 1'b1;
      bus.in_code = c1;
      step();
      bus.in_code = c2;
      step();
      bus.in_vld = 1'b0;
      step();
      chk($sformatf("sat_word%0d", w), cur(), e(1, 0, 0, {c1, c2}, 16'hFFFF));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
